vga_fb_fetcher: RTL and testbench
=================================

Name: vga_fb_fetcher

Overview:
- Shares one single-port framebuffer RAM between the VGA display path and a game-logic writer.
- Framebuffer holds COLS x ROWS cells, one DATA_W word per 8x8-pixel cell (80x60 for 640x480).
- Before each cell row is displayed, the block prefetches that row into a double-banked line buffer, then serves pixels from it.
- Writer accesses are granted only between prefetches; display fetch always has priority.

Parameters:
- DATA_W, 8: bits per cell word.
- COLS, 80: cells per row.
- ROWS, 60: cell rows per frame.
- CELL_SHIFT, 3: log2 of cell size in pixels.
- VLINES, 525: total lines per frame, including blanking.
- ADDR_W, 13: framebuffer address width.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous reset, active-high.
- vga_x  in  10  current pixel column from the timing generator.
- vga_y  in  10  current line from the timing generator.
- vga_valid  in  1  high in the active 640x480 region.
- newline  in  1  one-clk pulse; vga_y already holds the new line in that cycle.
- wr_req  in  1  writer request; held with wr_addr/wr_data until wr_ack.
- wr_addr  in  ADDR_W  cell address = row*COLS+col.
- wr_data  in  DATA_W  cell word to write.
- wr_ack  out  1  one-clk pulse in the cycle the write is issued.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data, valid 1 clk after the address is presented.
- pix_data  out  DATA_W  cell word for the current pixel (registered).
- busy  out  1  high while a fetch is in progress.
- underrun  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, pending trigger cleared, fetch row 0 armed.
- First cycle after rst deasserts: enter FETCH for row 0 unconditionally.
- Banking:
  - Row r is stored in bank r[0].
  - Display reads bank (vga_y>>CELL_SHIFT)[0] at index vga_x>>CELL_SHIFT.
  - No swap state is kept.
- Fetch trigger, evaluated on newline:
  - If (vga_y+1) mod 8 == 0 and (vga_y+1)>>3 < ROWS: fetch row (vga_y+1)>>3.
  - If vga_y == VLINES-1: fetch row 0.
  - Otherwise no trigger.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - Trigger or pending set: go to FETCH with k=0; wr_ack stays 0 this cycle.
  - Else if wr_req: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1 for exactly one cycle.
  - If wr_addr >= COLS*ROWS: wr_ack still pulses, but mem_we stays 0.
  - Back-to-back writes may be issued every cycle.
- FETCH:
  - For k=0..COLS-1, mem_addr = row*COLS+k and mem_we=0.
  - mem_rdata for index k-1 is captured into bank[row[0]][k-1].
  - After k=COLS-1, go to DRAIN.
- DRAIN: capture index COLS-1, then go to IDLE.
- A fetch occupies exactly COLS+1 cycles. busy=1 in FETCH and DRAIN.
- Trigger while not IDLE: latched into a one-deep pending slot (row stored). A later trigger overwrites it. It is serviced on return to IDLE.
- wr_req is never acked while busy. The writer stalls and must hold its inputs.
- underrun: set when newline arrives with vga_y mod 8 == 0, vga_y < 480, and either the fetch of row vga_y>>3 not yet complete or that row pending. Cleared only by rst.
- pix_data: 1-cycle latency from vga_x/vga_y. Equals 0 when vga_valid was 0 in the previous cycle.
- rst mid-fetch: fetch is abandoned, bank contents are undefined, and the row-0 fetch restarts after reset.

Test Plan:
- Release rst with RAM[k]=k+1 -> busy high for 81 cycles; mem_addr steps 0..79; bank0[k]=k+1; then IDLE with busy=0.
- newline with vga_y=7, RAM row1 = 0xA0+k -> fetch addresses 80..159; with vga_y=8, vga_x=24, vga_valid=1 -> pix_data=0xA3 one clk later.
- wr_req addr=5, data=0x3C while IDLE -> same cycle mem_we=1, mem_addr=5, wr_ack=1 for 1 clk. Repeat with addr=4800 -> wr_ack=1, mem_we=0.
- wr_req asserted in the same cycle as a trigger from vga_y=15 -> fetch of row 2 runs first. wr_ack arrives in the cycle after DRAIN; written data still reaches RAM.
- Force newline with vga_y=8 while the row-1 fetch is only 40 cycles in -> underrun=1, stays 1 until rst.
- newline with vga_y=524 -> fetch row 0 into bank 0. newline with vga_y=479 -> no fetch, busy stays 0.

Source files
------------

// File: rtl/vga_fb_fetcher.sv
// Framebuffer arbiter/prefetcher: shares one single-port cell RAM between the
// VGA display path (row prefetch into a two-bank line buffer) and a game-logic writer.
module vga_fb_fetcher #(
    parameter int DATA_W     = 8,
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int CELL_SHIFT = 3,
    parameter int VLINES     = 525,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    input  logic              vga_valid,
    input  logic              newline,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              busy,
    output logic              underrun
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int CELLS = COLS * ROWS;
    localparam logic [COL_W-1:0] LAST_K = COL_W'(COLS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  k_q, k_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              armed_q, armed_d;
    logic              pend_q, pend_d;
    logic [ROW_W-1:0]  pend_row_q, pend_row_d;
    logic [1:0]        bank_vld_q, bank_vld_d;
    logic [ROW_W-1:0]  bank_row_q [2];
    logic [ROW_W-1:0]  bank_row_d [2];
    logic              underrun_q, underrun_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              wr_ack_c;

    logic [DATA_W-1:0] bank_mem [2][COLS];
    logic              bank_we;
    logic              bank_sel;
    logic [COL_W-1:0]  bank_idx;

    logic              trig;
    logic [ROW_W-1:0]  trig_row;
    logic [10:0]       y_inc, y_cell;
    logic [9:0]        cur_cell, px_col;
    logic [ROW_W-1:0]  cur_row;
    logic              row_ready;
    logic [ROW_W-1:0]  start_row;
    logic [ADDR_W-1:0] start_base;

    // Fetch trigger: the line before each cell row starts, plus the last frame line for row 0.
    always_comb begin
        y_inc    = {1'b0, vga_y} + 11'd1;
        y_cell   = y_inc >> CELL_SHIFT;
        trig     = 1'b0;
        trig_row = '0;
        if (newline) begin
            if (y_inc[CELL_SHIFT-1:0] == '0 && y_cell < 11'(ROWS)) begin
                trig     = 1'b1;
                trig_row = ROW_W'(y_cell);
            end else if (vga_y == 10'(VLINES - 1)) begin
                trig     = 1'b1;
                trig_row = '0;
            end
        end
    end

    // A row is ready only once its bank holds that row and its fetch has drained.
    always_comb begin
        cur_cell   = vga_y >> CELL_SHIFT;
        cur_row    = ROW_W'(cur_cell);
        row_ready  = bank_vld_q[cur_row[0]] && (bank_row_q[cur_row[0]] == cur_row);
        underrun_d = underrun_q;
        if (newline && vga_y[CELL_SHIFT-1:0] == '0 && vga_y < 10'(ROWS << CELL_SHIFT) &&
            (!row_ready || (pend_q && pend_row_q == cur_row)))
            underrun_d = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        base_d      = base_q;
        armed_d     = armed_q;
        pend_d      = pend_q;
        pend_row_d  = pend_row_q;
        bank_vld_d  = bank_vld_q;
        bank_row_d  = bank_row_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ack_c    = 1'b0;
        bank_we     = 1'b0;
        bank_sel    = row_q[0];
        bank_idx    = k_q - COL_W'(1);
        start_row   = armed_q ? '0 : (pend_q ? pend_row_q : trig_row);
        start_base  = ADDR_W'(start_row) * ADDR_W'(COLS);
        unique case (state_q)
            IDLE: begin
                if (armed_q || pend_q || trig) begin
                    // A fresh trigger not consumed here waits in the pending slot.
                    pend_d     = trig && (armed_q || pend_q);
                    pend_row_d = trig ? trig_row : pend_row_q;
                    armed_d    = 1'b0;
                    state_d    = FETCH;
                    k_d        = '0;
                    row_d      = start_row;
                    base_d     = start_base;
                    mem_addr_d = start_base;
                    bank_vld_d[start_row[0]] = 1'b0;
                    bank_row_d[start_row[0]] = start_row;
                end else if (wr_req) begin
                    wr_ack_c    = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                    mem_we_d    = (wr_addr < ADDR_W'(CELLS));
                end
            end
            FETCH: begin
                if (trig) begin
                    pend_d     = 1'b1;
                    pend_row_d = trig_row;
                end
                bank_we = (k_q != '0);
                if (k_q == LAST_K) begin
                    state_d = DRAIN;
                end else begin
                    k_d        = k_q + COL_W'(1);
                    mem_addr_d = base_q + ADDR_W'(k_q) + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (trig) begin
                    pend_d     = 1'b1;
                    pend_row_d = trig_row;
                end
                bank_we  = 1'b1;
                bank_idx = LAST_K;
                bank_vld_d[row_q[0]] = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        px_col = vga_x >> CELL_SHIFT;
        pix_d  = '0;
        if (vga_valid && px_col < 10'(COLS))
            pix_d = bank_mem[vga_y[CELL_SHIFT]][COL_W'(px_col)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            row_q       <= '0;
            base_q      <= '0;
            armed_q     <= 1'b1;
            pend_q      <= 1'b0;
            pend_row_q  <= '0;
            bank_vld_q  <= '0;
            bank_row_q  <= '{default: '0};
            underrun_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            base_q      <= base_d;
            armed_q     <= armed_d;
            pend_q      <= pend_d;
            pend_row_q  <= pend_row_d;
            bank_vld_q  <= bank_vld_d;
            bank_row_q  <= bank_row_d;
            underrun_q  <= underrun_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            pix_q       <= pix_d;
        end
    end

    // Line buffer storage needs no reset; validity is tracked in bank_vld_q.
    always_ff @(posedge clk) begin
        if (bank_we)
            bank_mem[bank_sel][bank_idx] <= mem_rdata;
    end

    assign wr_ack    = wr_ack_c && !rst;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_data  = pix_q;
    assign busy      = (state_q != IDLE);
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_vga_fb_fetcher.sv
// Directed bench for vga_fb_fetcher with a 1-cycle-latency RAM model.
module tb_vga_fb_fetcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  vga_x = '0, vga_y = '0;
    logic        vga_valid = 1'b0, newline = 1'b0;
    logic        wr_req = 1'b0;
    logic [12:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pix_data;
    logic        busy, underrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] ram [0:8191];

    vga_fb_fetcher dut (
        .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .vga_valid(vga_valid),
        .newline(newline), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_data(pix_data), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int ack_early;
        for (int a = 0; a < 8192; a++) begin
            if (a < 80)       ram[a] = 8'(a + 1);
            else if (a < 160) ram[a] = 8'(8'hA0 + (a - 80));
            else if (a < 240) ram[a] = 8'(8'h50 + (a - 160));
            else              ram[a] = 8'(a);
        end

        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_pix", pix_data, 0);
        chk("rst_underrun", underrun, 0);

        // Initial row-0 fetch
        rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            chk("f0_busy", busy, 1);
            chk("f0_addr", mem_addr, k);
            chk("f0_we", mem_we, 0);
        end
        tick(); chk("f0_drain_busy", busy, 1);
        tick(); chk("f0_idle", busy, 0);

        vga_y = 10'd0; vga_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            vga_x = 10'(k * 8 + 3);
            tick();
            chk("bank0_pix", pix_data, k + 1);
        end
        vga_valid = 1'b0;
        tick(); chk("pix_invalid", pix_data, 0);

        // Row 1 fetch from newline at y=7
        vga_y = 10'd7; newline = 1'b1;
        tick(); newline = 1'b0;
        chk("f1_busy", busy, 1);
        chk("f1_addr0", mem_addr, 80);
        repeat (79) tick();
        chk("f1_addr79", mem_addr, 159);
        tick(); tick();
        chk("f1_idle", busy, 0);
        vga_y = 10'd8; vga_x = 10'd24; vga_valid = 1'b1;
        tick(); chk("f1_pix", pix_data, 8'hA3);
        vga_valid = 1'b0;

        // Writer access while idle
        wr_req = 1'b1; wr_addr = 13'd5; wr_data = 8'h3C;
        #1 chk("wr5_ack", wr_ack, 1);
        tick(); wr_req = 1'b0;
        chk("wr5_we", mem_we, 1);
        chk("wr5_addr", mem_addr, 5);
        chk("wr5_data", mem_wdata, 8'h3C);
        #1 chk("wr5_ack_gone", wr_ack, 0);
        tick();
        chk("wr5_we_gone", mem_we, 0);
        chk("wr5_ram", ram[5], 8'h3C);

        wr_req = 1'b1; wr_addr = 13'd4800; wr_data = 8'h77;
        #1 chk("wroob_ack", wr_ack, 1);
        tick(); wr_req = 1'b0;
        chk("wroob_we", mem_we, 0);
        tick();

        // Write colliding with a fetch trigger (row 2)
        vga_y = 10'd15; newline = 1'b1;
        wr_req = 1'b1; wr_addr = 13'd6; wr_data = 8'h5A;
        #1 chk("col_ack_trig", wr_ack, 0);
        tick(); newline = 1'b0;
        chk("col_busy", busy, 1);
        chk("col_addr", mem_addr, 160);
        ack_early = 0;
        for (int t = 2; t <= 81; t++) begin
            tick();
            if (wr_ack) ack_early++;
        end
        chk("col_ack_busy", ack_early, 0);
        tick();
        chk("col_idle", busy, 0);
        chk("col_ack", wr_ack, 1);
        tick(); wr_req = 1'b0;
        chk("col_we", mem_we, 1);
        chk("col_waddr", mem_addr, 6);
        tick();
        chk("col_ram", ram[6], 8'h5A);
        vga_y = 10'd16; vga_x = 10'd16; vga_valid = 1'b1;
        tick(); chk("f2_pix", pix_data, 8'h52);
        vga_valid = 1'b0;

        // Boundary lines: 479 no trigger, 524 refetches row 0
        vga_y = 10'd479; newline = 1'b1;
        tick(); newline = 1'b0;
        chk("y479_busy", busy, 0);
        tick(); chk("y479_busy2", busy, 0);
        vga_y = 10'd524; newline = 1'b1;
        tick(); newline = 1'b0;
        chk("y524_busy", busy, 1);
        chk("y524_addr", mem_addr, 0);
        repeat (81) tick();
        chk("y524_idle", busy, 0);
        vga_y = 10'd0; vga_valid = 1'b1;
        vga_x = 10'd40;  tick(); chk("r0_pix5", pix_data, 8'h3C);
        vga_x = 10'd48;  tick(); chk("r0_pix6", pix_data, 8'h5A);
        vga_x = 10'd632; tick(); chk("r0_pix79", pix_data, 80);
        vga_valid = 1'b0;
        chk("no_underrun", underrun, 0);

        // Underrun mid-fetch, plus a trigger left pending during the fetch
        vga_y = 10'd7; newline = 1'b1;
        tick(); newline = 1'b0;
        for (int t = 2; t <= 82; t++) begin
            if (t == 21) begin vga_y = 10'd15; newline = 1'b1; end
            if (t == 41) begin vga_y = 10'd8;  newline = 1'b1; end
            tick(); newline = 1'b0;
        end
        chk("ur_idle_gap", busy, 0);
        chk("ur_set", underrun, 1);
        tick();
        chk("pend_busy", busy, 1);
        chk("pend_addr", mem_addr, 160);
        repeat (81) tick();
        chk("pend_idle", busy, 0);
        vga_y = 10'd8; newline = 1'b1;
        tick(); newline = 1'b0;
        chk("ur_sticky", underrun, 1);

        // Reset in the middle of a fetch
        vga_y = 10'd7; newline = 1'b1;
        tick(); newline = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_underrun", underrun, 0);
        chk("mrst_addr", mem_addr, 0);
        rst = 1'b0;
        tick();
        chk("mrst_refetch", busy, 1);
        chk("mrst_addr0", mem_addr, 0);
        repeat (81) tick();
        chk("mrst_idle", busy, 0);
        vga_y = 10'd0; vga_x = 10'd0; vga_valid = 1'b1;
        tick(); chk("mrst_pix", pix_data, 1);
        vga_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
